// File: rtl/cdb_issue_unit.sv
// Round-robin issue arbiter that reserves the CDB slot each channel will write at its fixed latency.
// Optional ISSUE_PERF_CNT_EN adds saturating grant and stall counters.
module cdb_issue_unit #(
  parameter int                  NUM_CH      = 4,
  parameter int                  MAX_LAT     = 8,
  parameter logic [4*NUM_CH-1:0] CH_LAT      = {4'd7, 4'd4, 4'd2, 4'd1},
  parameter logic [NUM_CH-1:0]   CH_BLOCKING = 4'b1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] queue_ready,
  output logic [NUM_CH-1:0] issue_grant,
  output logic [NUM_CH-1:0] cdb_sel,
  output logic              cdb_sel_valid,
  output logic              stall_conflict
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_conflict_cnt
`endif
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chk
    if (CH_LAT[4*i +: 4] == 4'd0 || int'(CH_LAT[4*i +: 4]) > MAX_LAT) begin : g_bad
      $error("cdb_issue_unit: channel latency out of range 1..MAX_LAT");
    end
  end
  if (NUM_CH < 2 || NUM_CH > 8) begin : g_bad_num
    $error("cdb_issue_unit: NUM_CH must be 2..8");
  end

  function automatic logic [3:0] lat_of(input int i);
    return CH_LAT[4*i +: 4];
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [CW-1:0] i);
    logic [NUM_CH-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // occ_q[j]=1: the CDB slot j cycles ahead is reserved; own_q[j] names its channel
  logic [MAX_LAT:1]           occ_q, occ_d;
  logic [MAX_LAT:1][CW-1:0]   own_q, own_d;
  logic [CW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0][3:0]     busy_q, busy_d;
  logic [NUM_CH-1:0]          cdb_sel_q, cdb_sel_d;
  logic                       cdb_sel_valid_q, cdb_sel_valid_d;

  logic [NUM_CH-1:0]          eligible;
  logic                       grant_vld;
  logic [CW-1:0]              grant_idx;
  logic [3:0]                 grant_lat;

  always_comb begin
    eligible  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      eligible[i] = queue_ready[i] && !occ_q[int'(lat_of(i))] &&
                    !(CH_BLOCKING[i] && busy_q[i] != 4'd0);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = CW'(idx);
      end
    end
    if (rst) grant_vld = 1'b0;
    grant_lat      = lat_of(int'(grant_idx));
    issue_grant    = grant_vld ? onehot(grant_idx) : '0;
    stall_conflict = !rst && (|queue_ready) && !grant_vld;
  end

  always_comb begin
    for (int j = 1; j < MAX_LAT; j++) begin
      occ_d[j] = occ_q[j+1] | (grant_vld && int'(grant_lat) == j + 1);
      own_d[j] = (grant_vld && int'(grant_lat) == j + 1) ? grant_idx : own_q[j+1];
    end
    occ_d[MAX_LAT] = 1'b0;
    own_d[MAX_LAT] = '0;

    cdb_sel_valid_d = occ_q[1] | (grant_vld && grant_lat == 4'd1);
    if (grant_vld && grant_lat == 4'd1) cdb_sel_d = onehot(grant_idx);
    else if (occ_q[1])                  cdb_sel_d = onehot(own_q[1]);
    else                                cdb_sel_d = '0;

    if (!grant_vld)                           rr_ptr_d = rr_ptr_q;
    else if (int'(grant_idx) == NUM_CH - 1)   rr_ptr_d = '0;
    else                                      rr_ptr_d = grant_idx + CW'(1);

    // A blocking unit frees up in the cycle its result reaches the CDB
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_vld && int'(grant_idx) == i && CH_BLOCKING[i]) busy_d[i] = lat_of(i) - 4'd1;
      else if (busy_q[i] != 4'd0)                              busy_d[i] = busy_q[i] - 4'd1;
      else                                                     busy_d[i] = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q           <= '0;
      own_q           <= '0;
      rr_ptr_q        <= '0;
      busy_q          <= '0;
      cdb_sel_q       <= '0;
      cdb_sel_valid_q <= 1'b0;
    end else begin
      occ_q           <= occ_d;
      own_q           <= own_d;
      rr_ptr_q        <= rr_ptr_d;
      busy_q          <= busy_d;
      cdb_sel_q       <= cdb_sel_d;
      cdb_sel_valid_q <= cdb_sel_valid_d;
    end
  end

  assign cdb_sel       = cdb_sel_q;
  assign cdb_sel_valid = cdb_sel_valid_q;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_issue_cnt_q, perf_issue_cnt_d;
  logic [31:0] perf_conflict_cnt_q, perf_conflict_cnt_d;

  always_comb begin
    perf_issue_cnt_d    = perf_issue_cnt_q;
    perf_conflict_cnt_d = perf_conflict_cnt_q;
    if (grant_vld && perf_issue_cnt_q != 32'hFFFF_FFFF)
      perf_issue_cnt_d = perf_issue_cnt_q + 32'd1;
    if (stall_conflict && perf_conflict_cnt_q != 32'hFFFF_FFFF)
      perf_conflict_cnt_d = perf_conflict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt_q    <= '0;
      perf_conflict_cnt_q <= '0;
    end else begin
      perf_issue_cnt_q    <= perf_issue_cnt_d;
      perf_conflict_cnt_q <= perf_conflict_cnt_d;
    end
  end

  assign perf_issue_cnt    = perf_issue_cnt_q;
  assign perf_conflict_cnt = perf_conflict_cnt_q;
`endif

endmodule

// File: tb/tb_cdb_issue_unit.sv
// Bench for cdb_issue_unit: absolute-time CDB schedule model checked every cycle plus literal scenario checks.
module tb_cdb_issue_unit;
  localparam int NC      = 4;
  localparam int LAT_ALL = 'h7421;
  localparam int BLK_ALL = 'b1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NC-1:0] queue_ready = '0;
  logic [NC-1:0] issue_grant, cdb_sel;
  logic          cdb_sel_valid, stall_conflict;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0]   perf_issue_cnt, perf_conflict_cnt;
`endif

  cdb_issue_unit dut (
    .clk(clk), .rst(rst), .queue_ready(queue_ready),
    .issue_grant(issue_grant), .cdb_sel(cdb_sel),
    .cdb_sel_valid(cdb_sel_valid), .stall_conflict(stall_conflict)
`ifdef ISSUE_PERF_CNT_EN
    , .perf_issue_cnt(perf_issue_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Model: absolute cycle -> owning channel, plus the cycle each blocking unit frees up
  int sched[int];
  int busy_until[NC];
  int rr = 0;
  bit started = 0;

  function automatic int lat_m(input int i);
    return (LAT_ALL >> (4 * i)) & 15;
  endfunction

  always @(negedge clk) begin
    int g;
    int exp_cdb;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NC; k++) begin
        int c;
        c = (rr + k) % NC;
        if (g < 0 && queue_ready[c] && !sched.exists(cyc + lat_m(c)) && cyc >= busy_until[c]) g = c;
      end
    end
    exp_cdb = sched.exists(cyc) ? (1 << sched[cyc]) : 0;
    if (started) begin
      chk("m_grant", 32'(issue_grant), (g < 0) ? 0 : (1 << g));
      chk("m_stall", 32'(stall_conflict), (!rst && queue_ready != 0 && g < 0) ? 1 : 0);
      chk("m_cdb_sel", 32'(cdb_sel), exp_cdb);
      chk("m_cdb_valid", 32'(cdb_sel_valid), (exp_cdb != 0) ? 1 : 0);
      chk("m_onehot", 32'($onehot0(cdb_sel)), 1);
    end
    if (rst) begin
      sched.delete();
      for (int i = 0; i < NC; i++) busy_until[i] = 0;
      rr = 0;
      cyc = 0;
      started = 1;
    end else begin
      if (g >= 0) begin
        sched[cyc + lat_m(g)] = g;
        if ((BLK_ALL >> g) & 1) busy_until[g] = cyc + lat_m(g);
        rr = (g + 1) % NC;
      end
      cyc++;
    end
  end

  task automatic apply(input logic r, input logic [NC-1:0] q);
    @(posedge clk);
    #1;
    rst = r;
    queue_ready = q;
    #2;
  endtask

  task automatic rst2();
    apply(1'b1, '0);
    apply(1'b1, '0);
  endtask

  initial begin
    // 1: int alone wins every cycle
    rst2();
    chk("s1_rst_sel", 32'(cdb_sel), 0);
    chk("s1_rst_valid", 32'(cdb_sel_valid), 0);
    apply(1'b0, 4'b0001);
    chk("s1_grant0", 32'(issue_grant), 32'b0001);
    chk("s1_valid0", 32'(cdb_sel_valid), 0);
    apply(1'b0, 4'b0001);
    chk("s1_grant1", 32'(issue_grant), 32'b0001);
    chk("s1_sel1", 32'(cdb_sel), 32'b0001);
    chk("s1_valid1", 32'(cdb_sel_valid), 1);
    for (int t = 2; t < 6; t++) apply(1'b0, 4'b0001);

    // 2: all ready, round-robin and per-channel latency
    rst2();
    for (int t = 0; t < 20; t++) begin
      apply(1'b0, 4'b1111);
      if (t < 4)   chk("s2_grant_order", 32'(issue_grant), 32'(1 << t));
      if (t == 1)  chk("s2_sel_int", 32'(cdb_sel), 32'b0001);
      if (t == 3)  chk("s2_sel_mem", 32'(cdb_sel), 32'b0010);
      if (t == 6)  chk("s2_sel_mult", 32'(cdb_sel), 32'b0100);
      if (t == 10) chk("s2_sel_div", 32'(cdb_sel), 32'b1000);
    end

    // 3: CDB slot conflict between mult and mem
    rst2();
    apply(1'b0, 4'b0100);
    chk("s3_grant_mult", 32'(issue_grant), 32'b0100);
    apply(1'b0, 4'b0000);
    apply(1'b0, 4'b0010);
    chk("s3_blocked_grant", 32'(issue_grant), 0);
    chk("s3_blocked_stall", 32'(stall_conflict), 1);
    apply(1'b0, 4'b0010);
    chk("s3_grant_mem", 32'(issue_grant), 32'b0010);
    chk("s3_stall_clear", 32'(stall_conflict), 0);
    apply(1'b0, 4'b0000);
    chk("s3_sel_mult", 32'(cdb_sel), 32'b0100);
    apply(1'b0, 4'b0000);
    chk("s3_sel_mem", 32'(cdb_sel), 32'b0010);
`ifdef ISSUE_PERF_CNT_EN
    chk("s6_issue_cnt", perf_issue_cnt, 2);
    chk("s6_conflict_cnt", perf_conflict_cnt, 1);
    force dut.perf_issue_cnt_q = 32'hFFFF_FFFF;
    apply(1'b0, 4'b0000);
    release dut.perf_issue_cnt_q;
    apply(1'b0, 4'b0001);
    apply(1'b0, 4'b0000);
    chk("s6_saturate", perf_issue_cnt, 32'hFFFF_FFFF);
`endif

    // 4: non-pipelined div
    rst2();
    for (int t = 0; t < 16; t++) begin
      apply(1'b0, 4'b1000);
      chk("s4_div_grant", 32'(issue_grant), (t % 7 == 0) ? 32'b1000 : 0);
      if (t >= 1 && t <= 6) chk("s4_div_stall", 32'(stall_conflict), 1);
      if (t == 7 || t == 14) chk("s4_div_sel", 32'(cdb_sel), 32'b1000);
    end

    // 5: reset discards a pending CDB slot
    rst2();
    apply(1'b0, 4'b0100);
    chk("s5_grant_mult", 32'(issue_grant), 32'b0100);
    apply(1'b0, 4'b0000);
    apply(1'b1, 4'b1111);
    chk("s5_rst_grant", 32'(issue_grant), 0);
    chk("s5_rst_stall", 32'(stall_conflict), 0);
    apply(1'b1, 4'b0000);
    chk("s5_rst_sel", 32'(cdb_sel), 0);
    chk("s5_rst_valid", 32'(cdb_sel_valid), 0);
    apply(1'b0, 4'b0000);
    chk("s5_slot_dropped", 32'(cdb_sel_valid), 0);
    apply(1'b0, 4'b0000);

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
